// File: rtl/parallel2serial.sv
// Byte FIFO feeding an 8-bit serializer with one idle gap cycle per byte.
// Optional even-parity cycle after each byte when P2S_PARITY_EN is defined.
module parallel2serial #(
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    din_parallel,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          dout_serial,
    output logic                          dout_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef P2S_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  level;

    logic           push;
    logic           pop;

    logic [7:0]     shreg;
    logic [7:0]     shreg_nxt;
    logic [2:0]     cnt;
    logic [2:0]     cnt_nxt;
    logic           ser_q;
    logic           ser_nxt;
    logic           val_q;
    logic           val_nxt;

    // Bit i of the outgoing sequence for a given byte.
    function automatic logic pick(input logic [7:0] b, input logic [2:0] i);
        if (MSB_FIRST != 0) begin
            pick = b[3'd7 - i];
        end else begin
            pick = b[i];
        end
    endfunction

    assign din_ready   = (level < LW'(FIFO_DEPTH));
    assign push        = din_valid & din_ready;
    assign fifo_level  = level;
    assign dout_serial = ser_q;
    assign dout_valid  = val_q;
    assign busy        = (level != '0) || (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        ser_nxt   = 1'b0;
        val_nxt   = 1'b0;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    shreg_nxt = mem[rd_ptr];
                    cnt_nxt   = 3'd0;
                    ser_nxt   = pick(mem[rd_ptr], 3'd0);
                    val_nxt   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'd7) begin
`ifdef P2S_PARITY_EN
                    ser_nxt   = ^shreg;
                    val_nxt   = 1'b1;
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
`endif
                end else begin
                    ser_nxt = pick(shreg, cnt + 3'd1);
                    val_nxt = 1'b1;
                end
            end
`ifdef P2S_PARITY_EN
            PARITY: begin
                state_nxt = IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= 8'd0;
            cnt   <= 3'd0;
            ser_q <= 1'b0;
            val_q <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            ser_q <= ser_nxt;
            val_q <= val_nxt;
        end
    end

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= din_parallel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule
